// File: rtl/csa_pipe.sv
// csa_pipe: pipelined carry-select adder, {co,s} = a + b + ci, one register stage per SPB blocks, valid/ready flow control
//   clk, rst (async, active-high)           clock and reset
//   in_valid/in_ready, a, b, ci             operand handshake
//   out_valid/out_ready, s, co              registered result handshake
//   sub (only with CSA_PIPE_SUB_EN defined) 1 = a - b, co = no borrow
module csa_pipe #(
  parameter int WIDTH = 32,
  parameter int BLK = 4,
  parameter int SPB = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
`ifdef CSA_PIPE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co
);
  localparam int NBLK = WIDTH / BLK;
  localparam int NSTG = (NBLK + SPB - 1) / SPB;
  logic en;
  logic [NSTG-1:0] v_q, v_d, c_q, c_d;
  logic [NSTG-1:0][WIDTH-1:0] s_q, s_d, a_q, a_d, b_q, b_d;
  // index k is the input of stage k; index 0 is the external port side
  logic [NSTG:0] pv, pc;
  logic [NSTG:0][WIDTH-1:0] ps, pa, pb;
  logic [WIDTH-1:0] b0, ns;
  logic c0, cy, unused_ok;
  logic [BLK:0] r0, r1;
`ifdef CSA_PIPE_SUB_EN
  assign b0 = sub ? ~b : b;
  assign c0 = ci | sub;
`else
  assign b0 = b;
  assign c0 = ci;
`endif
  assign en = !out_valid | out_ready;
  assign in_ready = en;
  assign pv = {v_q, in_valid};
  assign pc = {c_q, c0};
  assign ps = {s_q, {WIDTH{1'b0}}};
  assign pa = {a_q, a};
  assign pb = {b_q, b0};
  // operand skew leaving the last stage has no consumer
  assign unused_ok = ^{pa[NSTG], pb[NSTG]};
  always_comb begin
    v_d = pv[NSTG-1:0];
    a_d = pa[NSTG-1:0];
    b_d = pb[NSTG-1:0];
    s_d = '0;
    c_d = '0;
    ns = '0;
    cy = 1'b0;
    r0 = '0;
    r1 = '0;
    for (int k = 0; k < NSTG; k++) begin
      cy = pc[k];
      ns = ps[k];
      for (int j = 0; j < NBLK; j++) begin
        if (j / SPB == k) begin
          r0 = {1'b0, pa[k][j*BLK +: BLK]} + {1'b0, pb[k][j*BLK +: BLK]};
          r1 = r0 + (BLK+1)'(1);
          {cy, ns[j*BLK +: BLK]} = cy ? r1 : r0;
        end
      end
      s_d[k] = ns;
      c_d[k] = cy;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      c_q <= '0;
      s_q <= '0;
      a_q <= '0;
      b_q <= '0;
    end else if (en) begin
      v_q <= v_d;
      c_q <= c_d;
      s_q <= s_d;
      a_q <= a_d;
      b_q <= b_d;
    end
  end
  assign out_valid = v_q[NSTG-1];
  assign s = s_q[NSTG-1];
  assign co = c_q[NSTG-1];
endmodule

// File: doc/csa_pipe.md
Name: csa_pipe

Overview:
- Parametrised, pipelined carry-select adder: successor to the fixed 16-bit, 4-bit-block carry-select adder.
- WIDTH-bit operands are split into BLK-bit blocks. Each block precomputes sum/carry for carry-in 0 and 1, and the incoming carry selects between them.
- A register stage is inserted after every SPB blocks. Operands enter and results leave through valid/ready handshakes with full backpressure.
- Used as the shared datapath adder wherever throughput matters more than single-cycle latency.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of BLK.
- BLK, 4, carry-select block width in bits; NBLK = WIDTH/BLK.
- SPB, 2, blocks evaluated per pipeline stage; NSTG = ceil(NBLK/SPB) = latency in cycles.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  a, b and ci are valid this cycle.
- in_ready  output  1  block accepts an input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- ci  input  1  carry-in.
- out_valid  output  1  s and co hold a result.
- out_ready  input  1  consumer accepts the result this cycle.
- s  output  WIDTH  sum, registered.
- co  output  1  carry-out of bit WIDTH-1, registered.

Behaviour:
- Reset (rst=1, async):
  - all stage valid bits, data, carry and skew registers clear to 0.
  - out_valid=0, s=0, co=0.
  - in_ready rises with the reset state, because the pipe is empty.
- Release is synchronous to clk. A reset asserted mid-operation discards all in-flight results; no partial outputs appear.
- Stage k (0..NSTG-1) handles blocks k*SPB .. min((k+1)*SPB, NBLK)-1:
  - Each block computes sum0/co0 (cin=0) and sum1/co1 (cin=1) combinationally from its operand bits.
  - The block's cin is the previous block's selected carry. The first block of stage 0 uses ci; the first block of stage k>0 uses the carry registered by stage k-1.
  - Selected sums go into the stage's sum register. Operand bits of blocks not yet evaluated travel forward in skew registers. Already-computed sum bits travel forward unchanged.
- Last stage registers drive s and co directly; no combinational path from a/b/ci to s/co.
- Global advance: en = !out_valid | out_ready.
  - in_ready = en (combinational).
  - When en=1, every stage register loads from its predecessor; stage 0 loads in_valid and the operands.
  - When en=0, all stages hold.
- Transfer rules:
  - Input is accepted iff in_valid & in_ready.
  - Output is consumed iff out_valid & out_ready.
  - Bubbles propagate as valid=0 slots and do not stall later stages when en=1.
- Latency: a transaction accepted at edge t is visible with out_valid=1 after edge t+NSTG-1, provided no stall occurs. Throughput is 1 per cycle when out_ready=1.
- Stall: while out_valid=1 and out_ready=0:
  - s, co and out_valid hold stable.
  - in_ready=0; a/b/ci are ignored.
- Ordering: strict FIFO. Results are never dropped or duplicated.
- Arithmetic: {co,s} = a + b + ci modulo 2^(WIDTH+1), exact for all inputs including all-ones wrap-around.
- Degenerate sizing:
  - SPB >= NBLK gives NSTG=1: a single registered stage, latency 1.
  - A final partial stage (NBLK not a multiple of SPB) is legal.

Optional Feature:
- Macro: CSA_PIPE_SUB_EN.
- Defined:
  - Adds port sub (input, 1), sampled with a/b on acceptance.
  - sub=1: stage 0 uses ~b and forces carry-in to 1 (ci ignored), so s = a - b mod 2^WIDTH and co = 1 iff a >= b unsigned (no borrow).
  - sub=0: behaves as addition.
- Not defined: no sub port; addition only.

Test Plan:
- Defaults, out_ready=1: a=0x0000_0003, b=0x0000_0004, ci=1 → s=0x0000_0008, co=0, out_valid exactly 4 cycles after acceptance.
- Carry across all blocks and stages: a=0xFFFF_FFFF, b=0x0000_0001, ci=0 → s=0x0000_0000, co=1. Also a=0xFFFF_FFFF, b=0xFFFF_FFFF, ci=1 → s=0xFFFF_FFFF, co=1.
- Streaming: 8 back-to-back inputs a=i, b=0x8000_0000·(i&1) for i=0..7, out_ready=1 → 8 in-order results on 8 consecutive cycles, in_ready constantly 1.
- Backpressure: fill the pipe, hold out_ready=0 for 5 cycles → in_ready=0, s/co/out_valid unchanged. Release → remaining results drain in order with none lost or repeated.
- Reset mid-stream: assert rst asynchronously with 3 transactions in flight → out_valid=0, s=0, co=0 immediately. After release, the first new input returns the correct sum after 4 cycles.
- CSA_PIPE_SUB_EN defined: sub=1, a=5, b=7 → s=0xFFFF_FFFE, co=0. sub=1, a=7, b=5 → s=2, co=1.
